sample_grid_buffer: RTL and testbench

//  Downstream of the CCD sample/clip stage. Collects the 1-bit sampled pixels (ipixel at d_srow_cont/d_scol_cont)

---
 rtl/sample_grid_pkg.sv | 22 ++
 rtl/bitmap_dpram.sv | 32 +++
 rtl/sample_grid_buffer.sv | 120 ++++++++++++
 tb/tb_sample_grid_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_grid_pkg.sv
// Shared constants and state type for the sample grid ping-pong bitmap buffer.
package sample_grid_pkg;

   localparam int GRID_W = 32;
   localparam int GRID_H = 32;
   localparam int IDX_W  = 5;
   localparam int CNT_W  = 11;

   // Flattened {row,col} cell index and full RAM address ({bank,row,col}).
   localparam int FLAT_W = 2 * IDX_W;
   localparam int ADDR_W = FLAT_W + 1;
   localparam int DEPTH  = 2 * GRID_W * GRID_H;

   localparam logic [FLAT_W-1:0] LAST_IDX = FLAT_W'(GRID_W * GRID_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      SWAP
   } grid_state_t;

endpackage

// File: rtl/bitmap_dpram.sv
// Two-bank 1-bit bitmap store: one write port and one registered read port.
module bitmap_dpram
   import sample_grid_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_data,
   input  logic              re,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data
);

   logic mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto block RAM; only the output register is reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data <= 1'b0;
      end else if (re) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sample_grid_buffer.sv
// Collects raster-ordered 1-bit samples into a ping-pong bitmap and exposes
// the last completed frame, with its set-pixel count, to readers.
module sample_grid_buffer
   import sample_grid_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sof,
   input  logic             s_valid,
   input  logic             ipixel,
   input  logic [IDX_W-1:0] d_srow_cont,
   input  logic [IDX_W-1:0] d_scol_cont,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_row,
   input  logic [IDX_W-1:0] rd_col,
   output logic             rd_data,
   output logic             rd_valid,
   output logic             frame_ready,
   output logic             frame_drop,
   output logic             seq_err,
   output logic             rd_bank,
   output logic [CNT_W-1:0] pixel_count
);

   grid_state_t       state;
   grid_state_t       state_nxt;
   logic              wr_bank;
   logic [FLAT_W-1:0] exp_idx;
   logic [FLAT_W-1:0] idx;
   logic [CNT_W-1:0]  run_cnt;
   logic              wr_en;
   logic              seq_miss;

   assign idx = {d_srow_cont, d_scol_cont};

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      seq_miss  = 1'b0;
      if (sof) begin
         // A new frame always wins, including over a same-cycle final-cell write.
         state_nxt = FILL;
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            FILL: begin
               if (s_valid) begin
                  if (idx == exp_idx) begin
                     wr_en = 1'b1;
                     if (idx == LAST_IDX) begin
                        state_nxt = SWAP;
                     end
                  end else begin
                     seq_miss = 1'b1;
                  end
               end
            end
            SWAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign frame_ready = (state == SWAP);

   // NOTE: all state below updates with non-blocking assignments so every process sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         rd_bank     <= 1'b0;
         wr_bank     <= 1'b1;
         exp_idx     <= '0;
         run_cnt     <= '0;
         seq_err     <= 1'b0;
         frame_drop  <= 1'b0;
         pixel_count <= '0;
         rd_valid    <= 1'b0;
      end else begin
         state      <= state_nxt;
         rd_valid   <= rd_en;
         frame_drop <= sof && (state == FILL);

         if (state == SWAP) begin
            rd_bank     <= wr_bank;
            pixel_count <= run_cnt;
         end

         if (sof) begin
            // Aim the writer at whichever bank is not (or is about to stop being) displayed.
            wr_bank <= (state == SWAP) ? ~wr_bank : ~rd_bank;
            exp_idx <= '0;
            run_cnt <= '0;
            seq_err <= 1'b0;
         end else begin
            if (wr_en) begin
               if (exp_idx != LAST_IDX) begin
                  exp_idx <= exp_idx + FLAT_W'(1);
               end
               run_cnt <= run_cnt + {{(CNT_W-1){1'b0}}, ipixel};
            end
            if (seq_miss) begin
               seq_err <= 1'b1;
            end
         end
      end
   end

   bitmap_dpram u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en),
      .wr_addr ({wr_bank, idx}),
      .wr_data (ipixel),
      .re      (rd_en),
      .rd_addr ({rd_bank, rd_row, rd_col}),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_sample_grid_buffer.sv
// Scoreboard bench for sample_grid_buffer: reads push expected bits, a monitor pops on rd_valid.
module tb_sample_grid_buffer;
   import sample_grid_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             sof;
   logic             s_valid;
   logic             ipixel;
   logic [IDX_W-1:0] d_srow_cont;
   logic [IDX_W-1:0] d_scol_cont;
   logic             rd_en;
   logic [IDX_W-1:0] rd_row;
   logic [IDX_W-1:0] rd_col;
   logic             rd_data;
   logic             rd_valid;
   logic             frame_ready;
   logic             frame_drop;
   logic             seq_err;
   logic             rd_bank;
   logic [CNT_W-1:0] pixel_count;

   sample_grid_buffer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sof         (sof),
      .s_valid     (s_valid),
      .ipixel      (ipixel),
      .d_srow_cont (d_srow_cont),
      .d_scol_cont (d_scol_cont),
      .rd_en       (rd_en),
      .rd_row      (rd_row),
      .rd_col      (rd_col),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .frame_ready (frame_ready),
      .frame_drop  (frame_drop),
      .seq_err     (seq_err),
      .rd_bank     (rd_bank),
      .pixel_count (pixel_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic data;
      int   cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   ready_cnt = 0;
   int   drop_cnt  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pulse counters and read-data scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset_n) begin
         if (frame_ready === 1'b1) ready_cnt++;
         if (frame_drop === 1'b1) drop_cnt++;
         if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rd_data", {31'd0, rd_data}, {31'd0, e.data});
               check("rd_latency", cyc, e.cyc + 1);
            end
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic pix(input int mode, input int r, input int c);
      case (mode)
         0:       return logic'(r == c);
         1:       return 1'b1;
         2:       return 1'b0;
         default: return logic'(c % 2);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_sof();
      sof = 1'b1;
      step();
      sof = 1'b0;
   endtask

   task automatic drive_one(input int r, input int c, input logic p);
      s_valid     = 1'b1;
      d_srow_cont = IDX_W'(r);
      d_scol_cont = IDX_W'(c);
      ipixel      = p;
      step();
      s_valid = 1'b0;
   endtask

   // Back-to-back raster writes of cells [start, start+n).
   task automatic write_range(input int mode, input int start, input int n);
      for (int i = start; i < start + n; i++) begin
         s_valid     = 1'b1;
         d_srow_cont = IDX_W'(i / GRID_W);
         d_scol_cont = IDX_W'(i % GRID_W);
         ipixel      = pix(mode, i / GRID_W, i % GRID_W);
         step();
      end
      s_valid = 1'b0;
   endtask

   task automatic read(input int r, input int c, input logic exp);
      exp_t e;
      e.data = exp;
      e.cyc  = cyc;
      sb.push_back(e);
      rd_en  = 1'b1;
      rd_row = IDX_W'(r);
      rd_col = IDX_W'(c);
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; sof = 1'b0; s_valid = 1'b0; ipixel = 1'b0;
      d_srow_cont = '0; d_scol_cont = '0;
      rd_en = 1'b0; rd_row = '0; rd_col = '0;
      step(); step();
      reset_n = 1'b1;
      check("rst_rd_bank", rd_bank, 0);
      check("rst_frame_ready", frame_ready, 0);
      check("rst_frame_drop", frame_drop, 0);
      check("rst_seq_err", seq_err, 0);
      check("rst_pixel_count", pixel_count, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);

      // 1: diagonal frame
      pulse_sof();
      write_range(0, 0, GRID_W * GRID_H);
      check("t1_frame_ready", frame_ready, 1);
      step();
      check("t1_frame_ready_low", frame_ready, 0);
      check("t1_rd_bank", rd_bank, 1);
      check("t1_pixel_count", pixel_count, 32);
      check("t1_ready_cnt", ready_cnt, 1);
      read(5, 5, 1'b1);
      read(5, 6, 1'b0);
      read(31, 31, 1'b1);
      read(0, 31, 1'b0);
      step();
      check("t1_rd_valid_idle", rd_valid, 0);

      // 2: all-ones frame, reads during fill see frame 1
      pulse_sof();
      write_range(1, 0, 512);
      read(5, 6, 1'b0);
      read(5, 5, 1'b1);
      write_range(1, 512, 512);
      check("t2_frame_ready", frame_ready, 1);
      step();
      check("t2_rd_bank", rd_bank, 0);
      check("t2_pixel_count", pixel_count, 1024);
      check("t2_ready_cnt", ready_cnt, 2);
      read(5, 6, 1'b1);
      // sample in IDLE is ignored
      drive_one(3, 7, 1'b0);
      check("t2_idle_no_seq_err", seq_err, 0);
      read(3, 7, 1'b1);

      // 3: out-of-order sample rejected, then sequence resumes
      pulse_sof();
      drive_one(0, 0, 1'b0);
      drive_one(0, 1, 1'b0);
      drive_one(0, 3, 1'b1);
      check("t3_seq_err", seq_err, 1);
      drive_one(0, 2, 1'b0);
      write_range(2, 3, GRID_W * GRID_H - 3);
      check("t3_frame_ready", frame_ready, 1);
      check("t3_seq_err_sticky", seq_err, 1);
      step();
      check("t3_rd_bank", rd_bank, 1);
      check("t3_pixel_count", pixel_count, 0);
      check("t3_ready_cnt", ready_cnt, 3);
      read(0, 0, 1'b0);
      read(0, 3, 1'b0);

      // 4: partial frame dropped by sof, then a full frame
      pulse_sof();
      check("t4_no_drop_from_idle", frame_drop, 0);
      check("t4_seq_err_cleared", seq_err, 0);
      write_range(1, 0, 500);
      pulse_sof();
      check("t4_frame_drop", frame_drop, 1);
      check("t4_rd_bank_kept", rd_bank, 1);
      check("t4_pixel_count_kept", pixel_count, 0);
      write_range(3, 0, GRID_W * GRID_H);
      check("t4_frame_ready", frame_ready, 1);
      step();
      check("t4_rd_bank", rd_bank, 0);
      check("t4_pixel_count", pixel_count, 512);
      check("t4_ready_cnt", ready_cnt, 4);
      check("t4_drop_cnt", drop_cnt, 1);
      read(2, 3, 1'b1);
      read(2, 4, 1'b0);

      // 5: sof coincides with the final-cell write
      pulse_sof();
      write_range(1, 0, GRID_W * GRID_H - 1);
      sof = 1'b1;
      drive_one(31, 31, 1'b1);
      sof = 1'b0;
      check("t5_frame_drop", frame_drop, 1);
      check("t5_no_frame_ready", frame_ready, 0);
      check("t5_rd_bank_kept", rd_bank, 0);
      write_range(0, 0, GRID_W * GRID_H);
      check("t5_frame_ready", frame_ready, 1);

      // 6: read issued in the SWAP cycle sees the old bank, next cycle the new one
      read(2, 2, 1'b0);
      read(2, 2, 1'b1);
      read(2, 3, 1'b0);
      check("t6_rd_bank", rd_bank, 1);
      check("t6_pixel_count", pixel_count, 32);
      check("t6_ready_cnt", ready_cnt, 5);
      check("t6_drop_cnt", drop_cnt, 2);

      step(); step();
      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
